// File: rtl/sr_ff_cmd_scheduler.sv
// Round-robin scheduler sharing a bank of SR flip-flops between requesters; never drives S=R=1.
// Optional SRSCHED_SKIP_EN: skip the DRIVE pulse when the target flop already holds the requested value.
module sr_ff_cmd_scheduler #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = 3,
    parameter int GIDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NFF-1:0]       S,
    output logic [NFF-1:0]       R,
    input  logic [NFF-1:0]       q_in,
    output logic                 busy,
    output logic [GIDW-1:0]      grant_id,
    output logic                 done,
    output logic                 err,
    output logic                 err_sticky,
    output logic [1:0]           dbg_state
);
    // Handshake: a requester holds req_valid/op/idx until it sees its one-cycle
    // req_ready pulse; the command is latched at the edge that raises req_ready.
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_VERIFY} state_t;

    localparam logic [IDXW:0] NFF_W = NFF[IDXW:0];

    state_t            state_q, state_d;
    logic [NFF-1:0]    s_q, s_d, r_q, r_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, sticky_q, sticky_d;
    logic [GIDW-1:0]   gid_q, gid_d, last_q, last_d;
    logic              op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              found;
    int                win;
    int                cand;
    logic              new_ok, cur_ok, skip;

    always_comb begin
        state_d = state_q;
        s_d     = '0;
        r_d     = '0;
        ready_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        gid_d   = gid_q;
        last_d  = last_q;
        op_d    = op_q;
        idx_d   = idx_q;
        found   = 1'b0;
        win     = 0;
        cand    = 0;
        new_ok  = 1'b0;
        cur_ok  = ({1'b0, idx_q} < NFF_W);
        skip    = 1'b0;

        // Search starts just after the previous winner so every requester gets a turn.
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    ready_d[win] = 1'b1;
                    op_d         = req_op[win];
                    idx_d        = req_idx[win*IDXW +: IDXW];
                    last_d       = GIDW'(win);
                    gid_d        = GIDW'(win);
                    busy_d       = 1'b1;
                    new_ok       = ({1'b0, idx_d} < NFF_W);
`ifdef SRSCHED_SKIP_EN
                    skip         = new_ok && (q_in[idx_d] == op_d);
`endif
                    if (skip) begin
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_DRIVE;
                        if (new_ok) begin
                            s_d[idx_d] = op_d;
                            r_d[idx_d] = ~op_d;
                        end
                    end
                end
            end
            ST_DRIVE: begin
                state_d = ST_VERIFY;
                busy_d  = 1'b1;
            end
            ST_VERIFY: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = !cur_ok || (q_in[idx_q] != op_q);
            end
            default: state_d = ST_IDLE;
        endcase

        sticky_d = sticky_q | err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            r_q      <= '0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            gid_q    <= '0;
            last_q   <= GIDW'(NREQ - 1);
            op_q     <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            r_q      <= r_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
        end
    end

    assign req_ready  = ready_q;
    assign S          = s_q;
    assign R          = r_q;
    assign busy       = busy_q;
    assign grant_id   = gid_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sr_ff_cmd_scheduler.sv
// Bench for sr_ff_cmd_scheduler: behavioural SR bank plus a transaction-timing reference model.
// Honours SRSCHED_SKIP_EN the same way the design does (skip latency 2 instead of 3).
module tb_sr_ff_cmd_scheduler;
    localparam int NREQ = 4;
    localparam int NFF  = 6;
    localparam int IDXW = 3;
    localparam int GIDW = 2;
    localparam int SL   = 8;
    localparam logic [NFF-1:0] Q_INIT = 6'b001010;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_op, req_ready;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NFF-1:0]       S, R, q_in;
    logic                 busy, done, err, err_sticky;
    logic [GIDW-1:0]      grant_id;
    logic [1:0]           dbg_state;

    sr_ff_cmd_scheduler #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW), .GIDW(GIDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
        .req_ready(req_ready), .S(S), .R(R), .q_in(q_in), .busy(busy), .grant_id(grant_id),
        .done(done), .err(err), .err_sticky(err_sticky), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // SR flip-flop bank with optional stuck-at faults on selected bits
    logic [NFF-1:0] q_bank = Q_INIT;
    logic [NFF-1:0] stuck_mask = '0, stuck_val = '0;
    always @(posedge clk) q_bank <= (q_bank | S) & ~R;
    assign q_in = (q_bank & ~stuck_mask) | (stuck_val & stuck_mask);

    int n_chk = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // requester side
    bit p_valid[NREQ], p_op[NREQ];
    int p_idx[NREQ], drop_at[NREQ];
    bit p_rst, random_mode;
    int refill_pct, arrive_pct, max_idx, rst_pct;

    // reference model
    int m_last, m_free, m_grant;
    bit m_sticky;
    logic [NFF-1:0] m_q = Q_INIT;
    logic [NREQ-1:0] e_ready[SL];
    logic [NFF-1:0]  e_s[SL], e_r[SL];
    bit e_done[SL], e_err[SL], e_busy[SL], e_gv[SL], e_rst[SL];
    int e_gid[SL];
    int glog[$];

    function automatic void clear_slot(int s);
        e_ready[s] = '0; e_s[s] = '0; e_r[s] = '0; e_done[s] = 0; e_err[s] = 0;
        e_busy[s] = 0; e_gv[s] = 0; e_rst[s] = 0; e_gid[s] = 0;
    endfunction

    task automatic new_cmd(input int i, input bit op, input int idx);
        p_valid[i] = 1; p_op[i] = op; p_idx[i] = idx;
    endtask

    function automatic bit eff_q(int idx);
        return stuck_mask[idx] ? stuck_val[idx] : m_q[idx];
    endfunction

    task automatic model_eval();
        int w, idx, lat, a;
        bit op, oor, skip, e, any;
        if (p_rst) begin
            for (int s = 0; s < SL; s++) clear_slot(s);
            e_rst[(cyc+1)%SL] = 1;
            m_last = NREQ - 1;
            m_free = cyc + 1;
            return;
        end
        any = 0;
        for (int i = 0; i < NREQ; i++) any |= p_valid[i];
        if (cyc < m_free || !any) return;
        w = -1;
        for (int k = 1; k <= NREQ && w < 0; k++)
            if (p_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        op = p_op[w]; idx = p_idx[w]; oor = (idx >= NFF); skip = 0;
`ifdef SRSCHED_SKIP_EN
        skip = !oor && (eff_q(idx) == op);
`endif
        if (oor) e = 1;
        else begin
            if (!skip) m_q[idx] = op;
            e = (eff_q(idx) != op);
        end
        lat = skip ? 2 : 3;
        a = (cyc + 1) % SL;
        e_ready[a] = NREQ'(1) << w;
        e_gv[a] = 1; e_gid[a] = w;
        if (!skip && !oor) begin
            e_s[a][idx] = op;
            e_r[a][idx] = !op;
        end
        for (int d = 1; d < lat; d++) e_busy[(cyc+d)%SL] = 1;
        e_done[(cyc+lat)%SL] = 1;
        e_err[(cyc+lat)%SL]  = e;
        m_free = cyc + lat;
        m_last = w;
        drop_at[w] = cyc + 2;
    endtask

    task automatic compare();
        int s = cyc % SL;
        if (e_rst[s]) begin m_grant = 0; m_sticky = 0; end
        if (e_gv[s]) m_grant = e_gid[s];
        if (e_err[s]) m_sticky = 1;
        chk("req_ready", req_ready, e_ready[s]);
        chk("S", S, e_s[s]);
        chk("R", R, e_r[s]);
        chk("busy", busy, e_busy[s]);
        chk("done", done, e_done[s]);
        chk("err", err, e_err[s]);
        chk("err_sticky", err_sticky, m_sticky);
        chk("grant_id", grant_id, m_grant);
        chk("s_and_r", S & R, 0);
        chk("one_line", $countones(S | R) <= 1, 1);
        if (|req_ready) glog.push_back(int'(grant_id));
        clear_slot(s);
    endtask

    task automatic tick();
        if (random_mode) p_rst = ($urandom_range(0, 999) < rst_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (drop_at[i] == cyc) begin
                p_valid[i] = 0;
                drop_at[i] = -1;
                if ($urandom_range(0, 99) < refill_pct)
                    new_cmd(i, 1'($urandom_range(0, 1)), $urandom_range(0, max_idx));
            end else if (random_mode && !p_valid[i] && $urandom_range(0, 99) < arrive_pct) begin
                new_cmd(i, 1'($urandom_range(0, 1)), $urandom_range(0, max_idx));
            end
        end
        rst = p_rst;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = p_valid[i];
            req_op[i]    = p_op[i];
            req_idx[i*IDXW +: IDXW] = IDXW'(p_idx[i]);
        end
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        p_rst = 1; ticks(2); p_rst = 0; tick();
    endtask

    initial begin
        for (int s = 0; s < SL; s++) clear_slot(s);
        for (int i = 0; i < NREQ; i++) begin
            p_valid[i] = 0; p_op[i] = 0; p_idx[i] = 0; drop_at[i] = -1;
        end
        m_last = NREQ - 1; m_free = 0; m_grant = 0; m_sticky = 0;
        random_mode = 0; refill_pct = 0; arrive_pct = 0; max_idx = NFF - 1; rst_pct = 0;

        // reset holds outputs quiet and leaves the bank alone
        p_rst = 1; ticks(2);
        chk("q_untouched", q_in, Q_INIT);
        p_rst = 0; tick();

        // single set on flop 5
        new_cmd(0, 1, 5); ticks(5);
        chk("q5_set", q_in[5], 1);

        // four contenders, round robin from requester 0
        do_reset();
        glog.delete();
        refill_pct = 100;
        for (int i = 0; i < NREQ; i++) new_cmd(i, 1'($urandom_range(0, 1)), $urandom_range(0, NFF-1));
        ticks(16);
        chk("rr_count", glog.size() >= 5, 1);
        if (glog.size() >= 5) begin
            chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1);
            chk("rr_g2", glog[2], 2); chk("rr_g3", glog[3], 3);
            chk("rr_g4", glog[4], 0);
        end
        refill_pct = 0; ticks(12);

        // reset of flop 2 with its Q stuck high
        stuck_mask = 6'b000100; stuck_val = 6'b000100;
        new_cmd(1, 0, 2); ticks(8);
        chk("sticky_hold", err_sticky, 1);
        stuck_mask = '0; stuck_val = '0;
        do_reset();
        chk("sticky_clr", err_sticky, 0);

        // out of range index, then reset during DRIVE
        new_cmd(2, 1, 7); ticks(5);
        new_cmd(0, 1, 1); tick();
        chk("in_drive", busy, 1);
        p_rst = 1; tick(); p_rst = 0; ticks(5);

        // already-set target: redundant pulse, or skipped when enabled
        stuck_mask = 6'b001000; stuck_val = 6'b001000;
        new_cmd(3, 1, 3); ticks(5);
        stuck_mask = '0; stuck_val = '0;

        // randomized traffic including out-of-range indices and occasional resets
        random_mode = 1; arrive_pct = 30; refill_pct = 50; max_idx = 7; rst_pct = 5;
        ticks(800);
        random_mode = 0; arrive_pct = 0; refill_pct = 0; p_rst = 0;
        for (int i = 0; i < NREQ; i++) if (drop_at[i] < 0) p_valid[i] = 0;
        ticks(20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
